// File: rtl/sub_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
// Optional build macro used by the datapath: SERIAL_SUB_SATURATE_EN.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Digit counter width; a one-digit configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    function automatic bit digit_divides(input int width, input int digit);
        return (digit > 0) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_sub_slice.sv
// Combinational DIGIT-bit slice of a + ~b + cin with ripple carry inside the digit.
module digit_sub_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout
);

    logic [DIGIT-1:0] g_s;
    logic [DIGIT-1:0] p_s;
    logic [DIGIT:0]   c_s;

    assign g_s = a_d & ~b_d;
    assign p_s = a_d ^ ~b_d;

    // Ripple the carry through the digit, starting from the incoming carry.
    always_comb begin
        c_s    = '0;
        s_d    = '0;
        c_s[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s_d[i]   = p_s[i] ^ c_s[i];
            c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
        end
    end

    assign cout = c_s[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b over WIDTH/DIGIT cycles, valid/ready in and out.
// Define SERIAL_SUB_SATURATE_EN to clamp an underflowing result to zero.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (!digit_divides(WIDTH, DIGIT)) begin : g_bad_digit
        $error("serial_subtractor: DIGIT must divide WIDTH exactly");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [DIGIT-1:0] s_s;
    logic             cout_s;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] diff_d;
    logic             zero_d;

    digit_sub_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a_d  (a_q[DIGIT-1:0]),
        .b_d  (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s_d  (s_s),
        .cout (cout_s)
    );

    // New digits enter at the MSB so the result is aligned after the last digit.
    if (WIDTH == DIGIT) begin : g_res_single
        assign res_d = s_s;
    end else begin : g_res_shift
        assign res_d = {s_s, res_q[WIDTH-1:DIGIT]};
    end

    // Final result value and its zero flag, as written on the last RUN cycle.
    always_comb begin
        diff_d = res_d;
`ifdef SERIAL_SUB_SATURATE_EN
        if (!cout_s) begin
            diff_d = '0;
        end else begin
            diff_d = res_d;
        end
`endif
        zero_d = (diff_d == '0);
    end

    // Control FSM and datapath registers; result registers change only on the final digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= 1'b1;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= cout_s;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        diff_q      <= diff_d;
                        borrow_q    <= ~cout_s;
                        zero_q      <= zero_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q     <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= DONE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios on DIGIT=2 plus a DIGIT sweep.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       z;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       iv [4];
    logic       ir [4];
    logic       ov [4];
    logic [7:0] df [4];
    logic       bw [4];
    logic       zr [4];

    int   checks;
    int   errors;
    exp_t sbq [$];

    for (genvar k = 0; k < 4; k++) begin : g_dut
        serial_subtractor #(
            .WIDTH(8),
            .DIGIT(1 << k)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[k]),
            .in_ready  (ir[k]),
            .a         (a),
            .b         (b),
            .out_valid (ov[k]),
            .out_ready (out_ready),
            .diff      (df[k]),
            .borrow    (bw[k]),
            .zero      (zr[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        e.d  = x - y;
        e.bo = (x < y);
`ifdef SERIAL_SUB_SATURATE_EN
        if (e.bo) e.d = 8'h00;
`endif
        e.z  = (e.d == 8'h00);
        return e;
    endfunction

    task automatic drive_op(input logic [7:0] x, input logic [7:0] y);
        int n;
        n = 0;
        while (!ir[1] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ir[1]) begin
            checks++; errors++;
            $display("FAIL accept_timeout in_ready=%0b required 1", ir[1]);
        end
        a = x; b = y; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        a = ~x; b = ~y;
        sbq.push_back(model(x, y));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!ov[1] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
        for (int k = 0; k < 4; k++) iv[k] = 1'b0;
        #12;
        checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", ir[1]); end
        checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", ov[1]); end
        checks++; if (df[1] !== 8'h00) begin errors++; $display("FAIL rst_diff got %h want 00", df[1]); end
        checks++; if (bw[1] !== 1'b0 || zr[1] !== 1'b0) begin errors++; $display("FAIL rst_flags got b=%0b z=%0b want 0 0", bw[1], zr[1]); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b want 1", ir[1]); end
    endtask

    task automatic test_basic;
        logic [7:0] va [5];
        logic [7:0] vb [5];
        int   lat;
        exp_t e;
        va[0] = 8'h5A; vb[0] = 8'h23;
        va[1] = 8'h10; vb[1] = 8'h20;
        va[2] = 8'h00; vb[2] = 8'hFF;
        va[3] = 8'hA5; vb[3] = 8'hA5;
        va[4] = 8'hC3; vb[4] = 8'h3C;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_op(va[i], vb[i]);
            checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL run_in_ready[%0d] got %0b want 0", i, ir[1]); end
            wait_out(lat);
            e = sbq.pop_front();
            checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 4", i, lat); end
            checks++; if (df[1] !== e.d) begin errors++; $display("FAIL basic_diff[%0d] got %h want %h", i, df[1], e.d); end
            checks++; if (bw[1] !== e.bo) begin errors++; $display("FAIL basic_borrow[%0d] got %0b want %0b", i, bw[1], e.bo); end
            checks++; if (zr[1] !== e.z) begin errors++; $display("FAIL basic_zero[%0d] got %0b want %0b", i, zr[1], e.z); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int   lat;
        exp_t e;
        out_ready = 1'b0;
        drive_op(8'h37, 8'h12);
        wait_out(lat);
        e = sbq.pop_front();
        checks++; if (ov[1] !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got %0b want 1", ov[1]); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ov[1] !== 1'b1 || ir[1] !== 1'b0 || df[1] !== e.d || bw[1] !== e.bo || zr[1] !== e.z) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%0b r=%0b d=%h b=%0b z=%0b want 1 0 %h %0b %0b",
                         i, ov[1], ir[1], df[1], bw[1], zr[1], e.d, e.bo, e.z);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (ov[1] !== 1'b0 || ir[1] !== 1'b1) begin errors++; $display("FAIL bp_release got v=%0b r=%0b want 0 1", ov[1], ir[1]); end
        drive_op(8'hFF, 8'h01);
        wait_out(lat);
        e = sbq.pop_front();
        checks++; if (df[1] !== e.d || df[1] !== 8'hFE) begin errors++; $display("FAIL bp_next_diff got %h want %h", df[1], e.d); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort;
        int   lat;
        exp_t e;
        out_ready = 1'b1;
        drive_op(8'h33, 8'h11);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        void'(sbq.pop_back());
        checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL abort_valid got %0b want 0", ov[1]); end
        checks++; if (df[1] !== 8'h00 || bw[1] !== 1'b0 || zr[1] !== 1'b0) begin errors++; $display("FAIL abort_result got d=%h b=%0b z=%0b want 00 0 0", df[1], bw[1], zr[1]); end
        checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL abort_in_ready got %0b want 0", ir[1]); end
        @(negedge clk); rst_n = 1'b1;
        drive_op(8'h80, 8'h7F);
        wait_out(lat);
        e = sbq.pop_front();
        checks++; if (lat !== 4) begin errors++; $display("FAIL abort_next_latency got %0d want 4", lat); end
        checks++; if (df[1] !== e.d || bw[1] !== e.bo) begin errors++; $display("FAIL abort_next got d=%h b=%0b want %h %0b", df[1], bw[1], e.d, e.bo); end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep;
        logic [7:0] x, y;
        logic       seen [4];
        int         lat  [4];
        logic [7:0] dss  [4];
        logic       bss  [4];
        logic       zss  [4];
        exp_t       e;
        int         n;
        out_ready = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            n = 0;
            while (!(ir[0] && ir[1] && ir[2] && ir[3]) && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            a = x; b = y;
            for (int k = 0; k < 4; k++) begin iv[k] = 1'b1; seen[k] = 1'b0; lat[k] = 0; end
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) iv[k] = 1'b0;
            a = 8'($urandom); b = 8'($urandom);
            sbq.push_back(model(x, y));
            for (int c = 1; c <= 12; c++) begin
                @(posedge clk); #1;
                for (int k = 0; k < 4; k++) begin
                    if (ov[k] && !seen[k]) begin
                        seen[k] = 1'b1; lat[k] = c;
                        dss[k] = df[k]; bss[k] = bw[k]; zss[k] = zr[k];
                    end
                end
            end
            e = sbq.pop_front();
            for (int k = 0; k < 4; k++) begin
                checks++; if (!seen[k] || lat[k] != (8 >> k)) begin errors++; $display("FAIL sweep_latency D=%0d a=%h b=%h got %0d want %0d", 1 << k, x, y, lat[k], 8 >> k); end
                checks++; if (dss[k] !== e.d) begin errors++; $display("FAIL sweep_diff D=%0d a=%h b=%h got %h want %h", 1 << k, x, y, dss[k], e.d); end
                checks++; if (bss[k] !== e.bo) begin errors++; $display("FAIL sweep_borrow D=%0d a=%h b=%h got %0b want %0b", 1 << k, x, y, bss[k], e.bo); end
                checks++; if (zss[k] !== e.z) begin errors++; $display("FAIL sweep_zero D=%0d a=%h b=%h got %0b want %0b", 1 << k, x, y, zss[k], e.z); end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
